// File: rtl/ysyx_23060072_lsu_stage.sv
// Memory-access pipeline stage: effective address, aligned byte/half/word bus access over req/gnt/rvalid,
// load extension and a registered writeback triple, with a saturating watchdog on stuck accesses.
module ysyx_23060072_lsu_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_flag_i,
  input  logic [4:0]  wb_addr_i,
  input  logic        load_flag_i,
  input  logic        store_flag_i,
  input  logic [1:0]  LSU_type_i,
  input  logic        LSU_signed_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [31:0] operand_imm_i,
  input  logic [31:0] wb_data_ex_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        lsu_hold_flag_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        wb_flag_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_WAIT = 2'b10;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_strb;
  logic          r_we;
  logic          r_signed;
  logic [1:0]    r_type;
  logic [1:0]    r_off;
  logic          r_wb_flag;
  logic [4:0]    r_wb_addr;
  logic          r_misalign;
  logic          r_wb_flag_o;
  logic [4:0]    r_wb_addr_o;
  logic [31:0]   r_wb_data_o;

  logic [31:0] w_ea;
  logic        w_memop;
  logic        w_misaligned;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic        w_in_idle;
  logic        w_in_req;
  logic        w_in_wait;
  logic        w_issue;
  logic        w_done;
  logic        w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_ea      = operand_a_i + operand_imm_i;
  assign w_memop   = load_flag_i | store_flag_i;
  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_req  = (r_state == S_REQ);
  assign w_in_wait = (r_state == S_WAIT);
  assign w_issue   = w_in_idle & w_memop & ~w_misaligned;

  // Reserved type 2'b11 falls into the word case for alignment, strobes and data.
  always_comb begin
    w_misaligned = 1'b0;
    w_strb       = 4'b1111;
    w_wdata      = operand_b_i;
    case (LSU_type_i)
      2'b00: begin
        w_strb  = 4'b0001 << w_ea[1:0];
        w_wdata = {4{operand_b_i[7:0]}};
      end
      2'b01: begin
        w_misaligned = w_ea[0];
        w_strb       = w_ea[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{operand_b_i[15:0]}};
      end
      default: w_misaligned = (w_ea[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    case (r_off)
      2'b00:   w_byte = mem_rdata_i[7:0];
      2'b01:   w_byte = mem_rdata_i[15:8];
      2'b10:   w_byte = mem_rdata_i[23:16];
      default: w_byte = mem_rdata_i[31:24];
    endcase
  end

  assign w_half = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    case (r_type)
      2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = mem_rdata_i;
    endcase
  end

  // A completion in the same cycle as the limit takes precedence over the abort.
  assign w_done    = (w_in_req & mem_gnt_i & r_we) | (w_in_wait & mem_rvalid_i);
  assign w_timeout = WDOG_EN && (w_in_req || w_in_wait) && (r_cnt == CNT_LIMIT) && !w_done;

  assign lsu_hold_flag_o = rst_n & ~w_timeout &
                           (w_issue | (w_in_req & ~(mem_gnt_i & r_we)) | (w_in_wait & ~mem_rvalid_i));
  assign mem_req_o   = w_in_req;
  assign bus_err_o   = w_timeout;
  assign misalign_o  = r_misalign;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wstrb_o = r_strb;
  assign mem_wdata_o = r_wdata;
  assign wb_flag_o   = r_wb_flag_o;
  assign wb_addr_o   = r_wb_addr_o;
  assign wb_data_o   = r_wb_data_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_we      <= 1'b0;
      r_signed  <= 1'b0;
      r_type    <= '0;
      r_off     <= '0;
      r_wb_flag <= 1'b0;
      r_wb_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_addr    <= {w_ea[31:2], 2'b00};
            r_we      <= store_flag_i;
            r_strb    <= w_strb;
            r_wdata   <= w_wdata;
            r_signed  <= LSU_signed_i;
            r_type    <= LSU_type_i;
            r_off     <= w_ea[1:0];
            r_wb_flag <= wb_flag_i;
            r_wb_addr <= wb_addr_i;
            r_cnt     <= '0;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_timeout)      r_state <= S_IDLE;
          else if (mem_gnt_i) r_state <= r_we ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid_i || w_timeout) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if ((w_in_req || w_in_wait) && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CW'(1);
    end
  end

  // Writeback registers: pass-through for ALU ops, load result on completion, bubble otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign  <= 1'b0;
      r_wb_flag_o <= 1'b0;
      r_wb_addr_o <= '0;
      r_wb_data_o <= '0;
    end else begin
      r_misalign <= w_in_idle & w_memop & w_misaligned;
      if (w_in_idle && !w_memop) begin
        r_wb_flag_o <= wb_flag_i;
        r_wb_addr_o <= wb_addr_i;
        r_wb_data_o <= wb_data_ex_i;
      end else if (w_in_wait && mem_rvalid_i) begin
        r_wb_flag_o <= r_wb_flag;
        r_wb_addr_o <= r_wb_addr;
        r_wb_data_o <= w_load_data;
      end else begin
        r_wb_flag_o <= 1'b0;
      end
    end
  end

endmodule
